// File: rtl/ex_if.sv
// Decode-to-execute / execute-to-memory bundle for ex_stage.
// Optional macro FWD_PREV2_EN adds the prev2 forward-select inputs.
interface ex_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            hold_in;
    logic            flush_in;
    logic [RA_W-1:0] rd_addr_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [XLEN-1:0] imm_in;
    logic            alu_rs2_reg_in;
    logic            writeback_en_in;
    logic            writeback_from_mem_in;
    logic            add_en_in;
    logic            sub_en_in;
    logic            xor_en_in;
    logic            or_en_in;
    logic            and_en_in;
    logic            skip_instr_in;
    logic            rs1_take_prev1_in;
    logic            rs2_take_prev1_in;
`ifdef FWD_PREV2_EN
    logic            rs1_take_prev2_in;
    logic            rs2_take_prev2_in;
`endif
    logic [RA_W-1:0] rd_addr_out;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic            writeback_en_out;
    logic            writeback_from_mem_out;
    logic            valid_out;
    logic            load_use_err_out;
    logic [31:0]     instr_count_out;

    modport master (
        output hold_in, flush_in, rd_addr_in, rs1_in, rs2_in, imm_in,
               alu_rs2_reg_in, writeback_en_in, writeback_from_mem_in,
               add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in,
               skip_instr_in, rs1_take_prev1_in, rs2_take_prev1_in,
`ifdef FWD_PREV2_EN
               rs1_take_prev2_in, rs2_take_prev2_in,
`endif
        input  rd_addr_out, alu_result_out, store_data_out, writeback_en_out,
               writeback_from_mem_out, valid_out, load_use_err_out, instr_count_out
    );

    modport slave (
        input  hold_in, flush_in, rd_addr_in, rs1_in, rs2_in, imm_in,
               alu_rs2_reg_in, writeback_en_in, writeback_from_mem_in,
               add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in,
               skip_instr_in, rs1_take_prev1_in, rs2_take_prev1_in,
`ifdef FWD_PREV2_EN
               rs1_take_prev2_in, rs2_take_prev2_in,
`endif
        output rd_addr_out, alu_result_out, store_data_out, writeback_en_out,
               writeback_from_mem_out, valid_out, load_use_err_out, instr_count_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 5-op ALU, EX/MEM register, retire counter.
// Optional macro FWD_PREV2_EN enables forwarding from the result two edges back.
module ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    localparam int unsigned CNT_W = 32;

    logic [RA_W-1:0]  r_rd_addr;
    logic [XLEN-1:0]  r_alu_result;
    logic [XLEN-1:0]  r_store_data;
    logic             r_wb_en;
    logic             r_wb_from_mem;
    logic             r_valid;
    logic             r_load_use_err;
    logic [CNT_W-1:0] r_instr_count;

    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_rs2_path;
    logic [XLEN-1:0]  w_op_b;
    logic [XLEN-1:0]  w_alu;
    logic             w_bubble;
    logic             w_load;
    logic             w_load_use;

`ifdef FWD_PREV2_EN
    logic [XLEN-1:0]  r_prev2;

    // Operand select; prev1 outranks prev2
    always_comb begin
        w_op_a     = bus.rs1_in;
        w_rs2_path = bus.rs2_in;
        if (bus.rs1_take_prev1_in)      w_op_a = r_alu_result;
        else if (bus.rs1_take_prev2_in) w_op_a = r_prev2;
        if (bus.rs2_take_prev1_in)      w_rs2_path = r_alu_result;
        else if (bus.rs2_take_prev2_in) w_rs2_path = r_prev2;
    end

    // prev2 shadows the EX/MEM result whenever the stage advances
    always_ff @(posedge clk) begin
        if (!rst)        r_prev2 <= '0;
        else if (w_load) r_prev2 <= r_alu_result;
    end
`else
    // Operand select from register file or prev1
    always_comb begin
        w_op_a     = bus.rs1_take_prev1_in ? r_alu_result : bus.rs1_in;
        w_rs2_path = bus.rs2_take_prev1_in ? r_alu_result : bus.rs2_in;
    end
`endif

    assign w_op_b     = bus.alu_rs2_reg_in ? w_rs2_path : bus.imm_in;
    assign w_bubble   = bus.skip_instr_in | bus.flush_in;
    assign w_load     = ~bus.hold_in | bus.flush_in;
    assign w_load_use = ~w_bubble & (bus.rs1_take_prev1_in | bus.rs2_take_prev1_in)
                        & r_wb_from_mem & r_valid;

    // Priority ALU: sub > add > xor > or > and, else 0
    always_comb begin
        w_alu = '0;
        if (bus.sub_en_in)      w_alu = w_op_a - w_op_b;
        else if (bus.add_en_in) w_alu = w_op_a + w_op_b;
        else if (bus.xor_en_in) w_alu = w_op_a ^ w_op_b;
        else if (bus.or_en_in)  w_alu = w_op_a | w_op_b;
        else if (bus.and_en_in) w_alu = w_op_a & w_op_b;
    end

    // EX/MEM register; bubbles keep the datapath values but drop control
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_addr      <= '0;
            r_alu_result   <= '0;
            r_store_data   <= '0;
            r_wb_en        <= 1'b0;
            r_wb_from_mem  <= 1'b0;
            r_valid        <= 1'b0;
            r_load_use_err <= 1'b0;
            r_instr_count  <= '0;
        end else if (w_load) begin
            r_alu_result   <= w_alu;
            r_store_data   <= w_rs2_path;
            r_rd_addr      <= w_bubble ? '0 : bus.rd_addr_in;
            r_wb_en        <= ~w_bubble & bus.writeback_en_in;
            r_wb_from_mem  <= ~w_bubble & bus.writeback_from_mem_in;
            r_valid        <= ~w_bubble;
            r_load_use_err <= w_load_use;
            if (!w_bubble) r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign bus.rd_addr_out            = r_rd_addr;
    assign bus.alu_result_out         = r_alu_result;
    assign bus.store_data_out         = r_store_data;
    assign bus.writeback_en_out       = r_wb_en;
    assign bus.writeback_from_mem_out = r_wb_from_mem;
    assign bus.valid_out              = r_valid;
    assign bus.load_use_err_out       = r_load_use_err;
    assign bus.instr_count_out        = r_instr_count;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage with a behavioural model and directed anchors.
module tb_ex_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    ex_if #(.XLEN(32), .RA_W(5)) bus ();

    ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        wb;
        logic        wbm;
        logic        valid;
        logic        lue;
        logic [31:0] cnt;
        logic [31:0] p2;
    } model_t;

    model_t m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Next architectural state from the current one and the applied inputs
    function automatic model_t model_next(input model_t c);
        model_t n;
        logic [31:0] a, r2, b, res;
        logic bub, p1_any;
        n = c;
        if (!rst) begin
            n = '{rd:0, alu:0, sd:0, wb:0, wbm:0, valid:0, lue:0, cnt:0, p2:0};
            return n;
        end
        if (bus.hold_in && !bus.flush_in) return n;
        a  = bus.rs1_in;
        r2 = bus.rs2_in;
`ifdef FWD_PREV2_EN
        if (bus.rs1_take_prev2_in) a  = c.p2;
        if (bus.rs2_take_prev2_in) r2 = c.p2;
`endif
        if (bus.rs1_take_prev1_in) a  = c.alu;
        if (bus.rs2_take_prev1_in) r2 = c.alu;
        b = bus.alu_rs2_reg_in ? r2 : bus.imm_in;
        if (bus.sub_en_in)      res = a - b;
        else if (bus.add_en_in) res = a + b;
        else if (bus.xor_en_in) res = a ^ b;
        else if (bus.or_en_in)  res = a | b;
        else if (bus.and_en_in) res = a & b;
        else                    res = 32'd0;
        bub    = bus.skip_instr_in || bus.flush_in;
        p1_any = bus.rs1_take_prev1_in || bus.rs2_take_prev1_in;
        n.p2    = c.alu;
        n.alu   = res;
        n.sd    = r2;
        n.valid = !bub;
        n.rd    = bub ? 5'd0 : bus.rd_addr_in;
        n.wb    = !bub && bus.writeback_en_in;
        n.wbm   = !bub && bus.writeback_from_mem_in;
        n.lue   = !bub && p1_any && c.wbm && c.valid;
        n.cnt   = bub ? c.cnt : c.cnt + 32'd1;
        return n;
    endfunction

    task automatic idle();
        bus.hold_in = 0; bus.flush_in = 0; bus.rd_addr_in = '0;
        bus.rs1_in = '0; bus.rs2_in = '0; bus.imm_in = '0;
        bus.alu_rs2_reg_in = 0; bus.writeback_en_in = 0; bus.writeback_from_mem_in = 0;
        bus.add_en_in = 0; bus.sub_en_in = 0; bus.xor_en_in = 0; bus.or_en_in = 0;
        bus.and_en_in = 0; bus.skip_instr_in = 1;
        bus.rs1_take_prev1_in = 0; bus.rs2_take_prev1_in = 0;
`ifdef FWD_PREV2_EN
        bus.rs1_take_prev2_in = 0; bus.rs2_take_prev2_in = 0;
`endif
    endtask

    task automatic randomize_inputs();
        bus.rd_addr_in = 5'($urandom);
        bus.rs1_in = $urandom; bus.rs2_in = $urandom; bus.imm_in = $urandom;
        bus.alu_rs2_reg_in = 1'($urandom); bus.writeback_en_in = 1'($urandom);
        bus.writeback_from_mem_in = 1'($urandom);
        bus.add_en_in = 1'($urandom); bus.sub_en_in = 1'($urandom);
        bus.xor_en_in = 1'($urandom); bus.or_en_in = 1'($urandom);
        bus.and_en_in = 1'($urandom);
        bus.skip_instr_in = ($urandom_range(0, 4) == 0);
        bus.rs1_take_prev1_in = 1'($urandom); bus.rs2_take_prev1_in = 1'($urandom);
`ifdef FWD_PREV2_EN
        bus.rs1_take_prev2_in = 1'($urandom); bus.rs2_take_prev2_in = 1'($urandom);
`endif
    endtask

    task automatic step();
        model_t nx;
        nx = model_next(m);
        @(posedge clk);
        m = nx;
        @(negedge clk);
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_addr",  32'(bus.rd_addr_out), 32'(m.rd));
            chk("alu",      bus.alu_result_out, m.alu);
            chk("store",    bus.store_data_out, m.sd);
            chk("wb_en",    32'(bus.writeback_en_out), 32'(m.wb));
            chk("wb_mem",   32'(bus.writeback_from_mem_out), 32'(m.wbm));
            chk("valid",    32'(bus.valid_out), 32'(m.valid));
            chk("load_use", 32'(bus.load_use_err_out), 32'(m.lue));
            chk("count",    bus.instr_count_out, m.cnt);
        end
    end

    initial begin
        checks = 0; failures = 0; chk_en = 0;
        m = '{rd:0, alu:0, sd:0, wb:0, wbm:0, valid:0, lue:0, cnt:0, p2:0};
        idle();
        rst = 0;
        @(negedge clk);
        step(); step();
        chk_en = 1;
        chk("rst_alu", bus.alu_result_out, 32'd0);
        chk("rst_cnt", bus.instr_count_out, 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        rst = 1;
        step();
        chk("idle_cnt", bus.instr_count_out, 32'd0);

        // add 5 + 7 -> 12
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 5;
        bus.imm_in = 7; bus.rd_addr_in = 3; bus.writeback_en_in = 1;
        step();
        chk("add_res", bus.alu_result_out, 32'd12);
        chk("add_rd", 32'(bus.rd_addr_out), 32'd3);
        chk("add_valid", 32'(bus.valid_out), 32'd1);
        chk("add_cnt", bus.instr_count_out, 32'd1);

        // sub 0-1, then xor forwarded with 0xF
        idle(); bus.skip_instr_in = 0; bus.sub_en_in = 1; bus.imm_in = 1;
        step();
        chk("sub_res", bus.alu_result_out, 32'hFFFF_FFFF);
        idle(); bus.skip_instr_in = 0; bus.xor_en_in = 1; bus.rs1_take_prev1_in = 1;
        bus.rs1_in = 32'h1234_5678; bus.imm_in = 32'hF;
        step();
        chk("xor_fwd", bus.alu_result_out, 32'hFFFF_FFF0);

        // load then consumer forwarding on rs2
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 100; bus.imm_in = 4;
        bus.writeback_en_in = 1; bus.writeback_from_mem_in = 1; bus.rd_addr_in = 7;
        step();
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 1;
        bus.alu_rs2_reg_in = 1; bus.rs2_take_prev1_in = 1; bus.rs2_in = 32'hDEAD;
        step();
        chk("lu_flag", 32'(bus.load_use_err_out), 32'd1);
        chk("lu_store", bus.store_data_out, 32'd104);
        chk("lu_res", bus.alu_result_out, 32'd105);
        chk("lu_cnt", bus.instr_count_out, 32'd5);

        // counter wrap via preset
        #2 force dut.r_instr_count = 32'hFFFF_FFFF;
        #1 release dut.r_instr_count;
        m.cnt = 32'hFFFF_FFFF;
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 1; bus.imm_in = 1;
        step();
        chk("wrap_cnt", bus.instr_count_out, 32'd0);

        // hold freezes, hold+flush loads a bubble
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 20; bus.imm_in = 22;
        bus.writeback_en_in = 1; bus.rd_addr_in = 9;
        step();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(); bus.hold_in = 1; bus.flush_in = 0; bus.skip_instr_in = 0;
            step();
        end
        chk("hold_res", bus.alu_result_out, 32'd42);
        chk("hold_cnt", bus.instr_count_out, 32'd1);
        randomize_inputs(); bus.hold_in = 1; bus.flush_in = 1;
        step();
        chk("hflush_valid", 32'(bus.valid_out), 32'd0);
        chk("hflush_cnt", bus.instr_count_out, 32'd1);

        // reset during a valid add
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 3; bus.imm_in = 3;
        bus.writeback_en_in = 1; bus.rd_addr_in = 2; rst = 0;
        step();
        chk("mid_rst_alu", bus.alu_result_out, 32'd0);
        chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("mid_rst_cnt", bus.instr_count_out, 32'd0);
        rst = 1;

`ifdef FWD_PREV2_EN
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_in = 4; bus.imm_in = 5;
        step();
        idle(); bus.skip_instr_in = 0; bus.or_en_in = 1; bus.rs1_in = 32'h100;
        step();
        idle(); bus.skip_instr_in = 0; bus.add_en_in = 1; bus.rs1_take_prev2_in = 1;
        bus.rs1_in = 32'h777; bus.imm_in = 0;
        step();
        chk("prev2_fwd", bus.alu_result_out, 32'd9);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            bus.hold_in  = ($urandom_range(0, 3) == 0);
            bus.flush_in = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) != 0);
            step();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
